// File: rtl/uart_rx_os16.sv
// UART receiver, 8N1 LSB-first, 16x oversampled, with false-start and framing-error detection.
// Define UART_RX_PARITY_EN for 8E1 frames: adds a PARITY state and the o_parity_err output.
module uart_rx_os16 #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_rx_busy
);

  localparam int unsigned TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (OVERSAMPLE != 16) begin : g_bad_os
    $error("uart_rx_os16: OVERSAMPLE must be 16");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif

  state_t              state, state_n;
  logic                rx_m, rx_s;
  logic [TICK_W-1:0]   tick_cnt, tick_cnt_n;
  logic                tick;
  logic [3:0]          s_cnt, s_cnt_n;
  logic [2:0]          b_cnt, b_cnt_n;
  logic [7:0]          shreg, shreg_n;
  logic [7:0]          rx_data_n;
  logic                done_n, ferr_n;
`ifdef UART_RX_PARITY_EN
  logic                par_bit, par_bit_n, perr_n;
`endif

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rx_m         <= 1'b1;
      rx_s         <= 1'b1;
      tick_cnt     <= '0;
      s_cnt        <= '0;
      b_cnt        <= '0;
      shreg        <= '0;
      rx_data      <= 8'h00;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_rx_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      rx_m         <= rx;
      rx_s         <= rx_m;
      tick_cnt     <= tick_cnt_n;
      s_cnt        <= s_cnt_n;
      b_cnt        <= b_cnt_n;
      shreg        <= shreg_n;
      rx_data      <= rx_data_n;
      o_rx_done    <= done_n;
      o_frame_err  <= ferr_n;
      o_rx_busy    <= (state_n != IDLE);
`ifdef UART_RX_PARITY_EN
      par_bit      <= par_bit_n;
      o_parity_err <= perr_n;
`endif
    end
  end

  // Next-state and datapath decode; all sampling happens on a tick at mid-bit
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick ? '0 : tick_cnt + TICK_W'(1);
    s_cnt_n    = s_cnt;
    b_cnt_n    = b_cnt;
    shreg_n    = shreg;
    rx_data_n  = rx_data;
    done_n     = 1'b0;
    ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n  = par_bit;
    perr_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          s_cnt_n    = 4'd0;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_cnt == 4'd7) begin
            if (!rx_s) begin
              state_n = DATA;
              s_cnt_n = 4'd0;
              b_cnt_n = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          s_cnt_n = s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            shreg_n = {rx_s, shreg[7:1]};
            b_cnt_n = b_cnt + 3'd1;
            if (b_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          s_cnt_n = s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
            par_bit_n = rx_s;
            state_n   = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          s_cnt_n = s_cnt + 4'd1;
          if (s_cnt == 4'd15) begin
`ifdef UART_RX_PARITY_EN
            perr_n = ((^shreg) != par_bit);
            if (rx_s && !perr_n) begin
`else
            if (rx_s) begin
`endif
              rx_data_n = shreg;
              done_n    = 1'b1;
            end
            ferr_n  = !rx_s;
            state_n = rx_s ? IDLE : BRK;
          end
        end
      end
      BRK: begin
        // A line held low must go idle before a new start bit is accepted
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed bench for uart_rx_os16: table of whole frames plus glitch, reset-abort and parity sequences.
module tb_uart_rx_os16;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned BIT_CLK  = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       o_rx_done, o_frame_err, o_rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  uart_rx_os16 #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_data(rx_data),
    .o_rx_done(o_rx_done),
    .o_frame_err(o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_rx_busy(o_rx_busy)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] done_data = 8'h00;
  logic       both_seen = 1'b0;

  // Pulse monitor
  always @(negedge clk) begin
    if (o_rx_done) begin
      done_cnt  <= done_cnt + 1;
      done_data <= rx_data;
    end
    if (o_frame_err) ferr_cnt <= ferr_cnt + 1;
    if (o_rx_done && o_frame_err) both_seen <= 1'b1;
`ifdef UART_RX_PARITY_EN
    if (o_parity_err) perr_cnt <= perr_cnt + 1;
`endif
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int hold_low);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop);
    if (!stop) repeat (hold_low) @(negedge clk);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         gap;
    int         exp_done;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int d0, f0, p0;

    vecs[0] = '{data: 8'h01, stop: 1'b1, hold: 0,   gap: 0,  exp_done: 1, exp_ferr: 0, exp_data: 8'h01};
    vecs[1] = '{data: 8'hAA, stop: 1'b1, hold: 0,   gap: 20, exp_done: 1, exp_ferr: 0, exp_data: 8'hAA};
    vecs[2] = '{data: 8'h55, stop: 1'b0, hold: 500, gap: 20, exp_done: 0, exp_ferr: 1, exp_data: 8'hAA};
    vecs[3] = '{data: 8'h3C, stop: 1'b1, hold: 0,   gap: 20, exp_done: 1, exp_ferr: 0, exp_data: 8'h3C};
    vecs[4] = '{data: 8'h00, stop: 1'b1, hold: 0,   gap: 0,  exp_done: 1, exp_ferr: 0, exp_data: 8'h00};
    vecs[5] = '{data: 8'hFF, stop: 1'b1, hold: 0,   gap: 20, exp_done: 1, exp_ferr: 0, exp_data: 8'hFF};

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_done", o_rx_done, 0);
    check("reset_ferr", o_frame_err, 0);
    check("reset_busy", o_rx_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Frame table
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold);
      repeat (vecs[i].gap) @(negedge clk);
      check($sformatf("row%0d_done_pulses", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("row%0d_ferr_pulses", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("row%0d_rx_data", i), rx_data, vecs[i].exp_data);
      check($sformatf("row%0d_busy", i), o_rx_busy, 0);
      if (vecs[i].exp_done != 0)
        check($sformatf("row%0d_data_at_done", i), done_data, vecs[i].exp_data);
    end

    // False start: 40-clk low glitch
    d0 = done_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_during", o_rx_busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_done_pulses", done_cnt - d0, 0);
    check("glitch_ferr_pulses", ferr_cnt - f0, 0);
    check("glitch_rx_data", rx_data, 8'hFF);
    check("glitch_busy_after", o_rx_busy, 0);

    // Reset in the 4th data bit of 0xF0, then receive 0x0F
    d0 = done_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    check("midframe_busy", o_rx_busy, 1);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_busy", o_rx_busy, 0);
    reset = 1'b0;
    repeat (BIT_CLK * 10) @(negedge clk);
    check("midreset_no_strobe", done_cnt - d0, 0);
    send_frame(8'h0F, 1'b1, 0);
    repeat (20) @(negedge clk);
    check("after_reset_done_pulses", done_cnt - d0, 1);
    check("after_reset_rx_data", rx_data, 8'h0F);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so the even-parity bit is 1
    d0 = done_cnt;
    p0 = perr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(1'(8'h07 >> i));
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (20) @(negedge clk);
    check("par_ok_done", done_cnt - d0, 1);
    check("par_ok_perr", perr_cnt - p0, 0);
    check("par_ok_rx_data", rx_data, 8'h07);
    rx_data_prev_check: begin
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(1'(8'h07 >> i));
      drive_bit(1'b0);
      drive_bit(1'b1);
      repeat (20) @(negedge clk);
    end
    check("par_bad_done", done_cnt - d0, 1);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_rx_data", rx_data, 8'h07);
`else
    p0 = perr_cnt;
    check("no_parity_pulses", perr_cnt - p0, 0);
`endif

    check("done_ferr_exclusive", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
